// File: rtl/grf_pkg.sv
// Shared GRF constants and the write-back entry layout.
// Used by grf_wb_queue and grf_wb_lookup.
package grf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_lookup.sv
// Youngest-first match of one read address against the
// pending write-back entries.
module grf_wb_lookup
    import grf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [DEPTH-1:0]        i_vld,
    input  logic [DEPTH*ADDR_W-1:0] i_addr,
    input  logic [DEPTH*DATA_W-1:0] i_data,
    input  logic [$clog2(DEPTH)-1:0] i_tail,
    input  logic [ADDR_W-1:0]       i_rd_addr,
    output logic                    o_hit,
    output logic [DATA_W-1:0]       o_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] w_idx;
    logic          w_rd_nz;

    assign w_rd_nz = (i_rd_addr != ADDR_W'(REG_ZERO));

    // Walk back from the slot just behind the tail; first hit wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_idx = i_tail - PW'(k);
            if (!o_hit && w_rd_nz && i_vld[w_idx] &&
                i_addr[w_idx*ADDR_W +: ADDR_W] == i_rd_addr) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/grf_wb_queue.sv
// In-order write-back queue in front of the GRF write port.
// Define GRF_WB_TRACE_EN to print each retired GRF write.
module grf_wb_queue
    import grf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     grf_we,
    output logic [31:0]              grf_pc,
    output logic [ADDR_W-1:0]        grf_a3,
    output logic [DATA_W-1:0]        grf_wd,
    input  logic [ADDR_W-1:0]        rd_a1,
    input  logic [ADDR_W-1:0]        rd_a2,
    output logic                     hit1,
    output logic [DATA_W-1:0]        fwd1,
    output logic                     hit2,
    output logic [DATA_W-1:0]        fwd2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic [DEPTH-1:0]        r_vld;
    logic [31:0]             r_pc [DEPTH];
    logic [DEPTH*ADDR_W-1:0] r_addr;
    logic [DEPTH*DATA_W-1:0] r_data;

    logic w_push;
    logic w_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign in_ready = !full;

    // $0 writes complete the handshake but are dropped here.
    assign w_push = in_valid && in_ready &&
                    (in_addr != ADDR_W'(REG_ZERO));
    assign w_pop  = grf_we;

    // A reset cycle must not leak a write into the GRF.
    assign grf_we = !empty && drain_en && !reset;
    assign grf_pc = grf_we ? r_pc[r_rptr] : '0;
    assign grf_a3 = grf_we ? r_addr[r_rptr*ADDR_W +: ADDR_W] : '0;
    assign grf_wd = grf_we ? r_data[r_rptr*DATA_W +: DATA_W] : '0;

    // Queue state: tail write on push, head release on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wptr]                   <= in_pc;
                r_addr[r_wptr*ADDR_W +: ADDR_W] <= in_addr;
                r_data[r_wptr*DATA_W +: DATA_W] <= in_data;
                r_vld[r_wptr]                  <= 1'b1;
                r_wptr                         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    grf_wb_lookup #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_lk1 (
        .i_vld    (r_vld),
        .i_addr   (r_addr),
        .i_data   (r_data),
        .i_tail   (r_wptr),
        .i_rd_addr(rd_a1),
        .o_hit    (hit1),
        .o_data   (fwd1)
    );

    grf_wb_lookup #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_lk2 (
        .i_vld    (r_vld),
        .i_addr   (r_addr),
        .i_data   (r_data),
        .i_tail   (r_wptr),
        .i_rd_addr(rd_a2),
        .o_hit    (hit2),
        .o_data   (fwd2)
    );

`ifdef GRF_WB_TRACE_EN
    // Trace every write the GRF commits on this edge.
    always_ff @(posedge clk) begin
        if (grf_we)
            $display("@%h: $%0d <= %h", grf_pc, grf_a3, grf_wd);
    end
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// Scoreboard bench for grf_wb_queue: expected GRF writes are
// queued at issue and checked by a monitor on the write port.
module tb_grf_wb_queue;
    import grf_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_en;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        hit1;
    logic [31:0] fwd1;
    logic        hit2;
    logic [31:0] fwd2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int checks = 0;
    int failures = 0;

    wb_entry_t   exp_q[$];
    logic [31:0] tb_grf [32];

    grf_wb_queue dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc   (in_pc),
        .in_addr (in_addr),
        .in_data (in_data),
        .drain_en(drain_en),
        .grf_we  (grf_we),
        .grf_pc  (grf_pc),
        .grf_a3  (grf_a3),
        .grf_wd  (grf_wd),
        .rd_a1   (rd_a1),
        .rd_a2   (rd_a2),
        .hit1    (hit1),
        .fwd1    (fwd1),
        .hit2    (hit2),
        .fwd2    (fwd2),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc,
                        input logic [4:0]  a,
                        input logic [31:0] d);
        wb_entry_t e;
        in_valid = 1'b1;
        in_pc    = pc;
        in_addr  = a;
        in_data  = d;
        @(negedge clk);
        chk("push_ready", in_ready, 1);
        if (a != 5'd0) begin
            e.pc   = pc;
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        cyc();
        in_valid = 1'b0;
    endtask

    // Monitor: every GRF write must match the oldest expected one.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (grf_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_we: a3=%0d wd=%0h",
                             grf_a3, grf_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", grf_pc, e.pc);
                    chk("mon_a3", grf_a3, e.addr);
                    chk("mon_wd", grf_wd, e.data);
                    tb_grf[grf_a3] = grf_wd;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32; i++) tb_grf[i] = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_pc    = '0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b1;
        rd_a1    = '0;
        rd_a2    = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_we", grf_we, 0);
        chk("rst_count", count, 0);
        cyc();
        reset = 1'b0;

        // Single write, drain enabled.
        push(32'h3000, 5'd5, 32'h11);
        @(negedge clk);
        chk("t1_we", grf_we, 1);
        chk("t1_a3", grf_a3, 5);
        cyc();
        @(negedge clk);
        chk("t1_empty", empty, 1);
        chk("t1_we_off", grf_we, 0);
        chk("t1_a3_zero", grf_a3, 0);
        cyc();

        // Fill, reject a fifth, drain in order.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++)
            push(32'h4000 + 32'(4 * i), 5'(i), 32'h100 + 32'(i));
        in_valid = 1'b1;
        in_pc    = 32'h4100;
        in_addr  = 5'd9;
        in_data  = 32'h999;
        @(negedge clk);
        chk("t2_full", full, 1);
        chk("t2_ready", in_ready, 0);
        chk("t2_count", count, 4);
        cyc();
        in_valid = 1'b0;
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_drain_we", grf_we, 1);
            chk("t2_drain_a3", grf_a3, i);
            cyc();
        end
        @(negedge clk);
        chk("t2_empty", empty, 1);
        cyc();

        // Same register twice: youngest bypass, oldest retires first.
        drain_en = 1'b0;
        rd_a1 = 5'd7;
        rd_a2 = 5'd7;
        push(32'h5000, 5'd7, 32'hA);
        push(32'h5004, 5'd7, 32'hB);
        @(negedge clk);
        chk("t3_hit1", hit1, 1);
        chk("t3_fwd1", fwd1, 32'hB);
        chk("t3_hit2", hit2, 1);
        chk("t3_fwd2", fwd2, 32'hB);
        cyc();
        drain_en = 1'b1;
        @(negedge clk);
        chk("t3_ret_hit1", hit1, 1);
        chk("t3_ret_fwd1", fwd1, 32'hB);
        cyc();
        @(negedge clk);
        chk("t3_last_hit1", hit1, 1);
        chk("t3_last_fwd1", fwd1, 32'hB);
        cyc();
        @(negedge clk);
        chk("t3_done_hit1", hit1, 0);
        chk("t3_done_fwd1", fwd1, 0);
        chk("t3_grf7", tb_grf[7], 32'hB);
        cyc();

        // $0 write is swallowed; same-cycle enqueue is invisible.
        rd_a2 = 5'd0;
        push(32'h6000, 5'd0, 32'hFFFF);
        @(negedge clk);
        chk("t4_count", count, 0);
        chk("t4_empty", empty, 1);
        chk("t4_we", grf_we, 0);
        chk("t4_hit2", hit2, 0);
        chk("t4_fwd2", fwd2, 0);
        cyc();
        rd_a1 = 5'd3;
        push(32'h6004, 5'd3, 32'h33);
        rd_a1 = 5'd0;
        cyc();
        cyc();

        // Full with drain: pop only, then push+pop together.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h7000 + 32'(4 * i), 5'(10 + i), 32'h10 + 32'(i));
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h7010;
        in_addr  = 5'd14;
        in_data  = 32'hE;
        @(negedge clk);
        chk("t5_ready_full", in_ready, 0);
        chk("t5_we_full", grf_we, 1);
        chk("t5_count4", count, 4);
        cyc();
        @(negedge clk);
        chk("t5_ready_next", in_ready, 1);
        chk("t5_count3", count, 3);
        exp_q.push_back('{pc: 32'h7010, addr: 5'd14, data: 32'hE});
        cyc();
        in_valid = 1'b0;
        drain_en = 1'b0;
        @(negedge clk);
        chk("t5_count_pp", count, 3);
        cyc();
        drain_en = 1'b1;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("t5_empty", empty, 1);
        cyc();

        // Reset with entries pending discards them.
        drain_en = 1'b0;
        push(32'h8000, 5'd20, 32'h20);
        push(32'h8004, 5'd21, 32'h21);
        push(32'h8008, 5'd22, 32'h22);
        @(negedge clk);
        chk("t6_count3", count, 3);
        cyc();
        reset    = 1'b1;
        drain_en = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_we_rst", grf_we, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_we_after", grf_we, 0);
        cyc();
        cyc();
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
